id_hazard_stage: RTL

ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

---
 rtl/id_pkg.sv | 91 +++++++++
 rtl/id_hazard_stage_if.sv | 54 +++++
 rtl/id_regfile.sv | 40 ++++
 rtl/id_hazard_stage.sv | 118 +++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Decode-stage package: opcode/funct encodings, halt marker, control bundle,
// halt-drain state encoding and the main decoder.
package id_pkg;

  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       reg_dst;
    logic [5:0] alu_op;
    logic [5:0] alu_funct;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } halt_state_e;

  // Opcode/funct to control bundle; unknown encodings leave every flag low.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c           = '0;
    c.alu_op    = op;
    c.alu_funct = fn;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_JR: c.jump = 1'b1;
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
          F_SLT, F_SLTU: begin
            c.reg_write = 1'b1;
            c.reg_dst   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW:                                      c.mem_write = 1'b1;
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: c.reg_write = 1'b1;
      OP_BEQ, OP_BNE:                             c.branch    = 1'b1;
      OP_J:                                       c.jump      = 1'b1;
      OP_JAL: begin
        c.jump      = 1'b1;
        c.reg_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_hazard_stage_if.sv
// Fetch/write-back/EX inputs and decode outputs of the ID stage.
interface id_hazard_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
);
  logic [31:0]   instr_in;
  logic [31:0]   pc_plus4_in;
  logic          flush_in;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          ex_memtoreg;
  logic [AW-1:0] ex_rt_addr;

  logic          stall_out;
  logic          valid_out;
  logic [31:0]   pc_plus4_out;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [AW-1:0] rd_addr;
  logic [4:0]    shamt;
  logic [31:0]   imm_sext;
  logic [31:0]   imm_zext;
  logic [25:0]   jaddr;
  logic          reg_write;
  logic          mem_to_reg;
  logic          mem_write;
  logic          branch;
  logic          jump;
  logic          reg_dst;
  logic [5:0]    alu_op;
  logic [5:0]    alu_funct;
  logic          halt_out;

  modport master (
    output instr_in, pc_plus4_in, flush_in, wb_we, wb_addr, wb_data,
           ex_memtoreg, ex_rt_addr,
    input  stall_out, valid_out, pc_plus4_out, rs_data, rt_data, rs_addr,
           rt_addr, rd_addr, shamt, imm_sext, imm_zext, jaddr, reg_write,
           mem_to_reg, mem_write, branch, jump, reg_dst, alu_op, alu_funct,
           halt_out
  );

  modport slave (
    input  instr_in, pc_plus4_in, flush_in, wb_we, wb_addr, wb_data,
           ex_memtoreg, ex_rt_addr,
    output stall_out, valid_out, pc_plus4_out, rs_data, rt_data, rs_addr,
           rt_addr, rd_addr, shamt, imm_sext, imm_zext, jaddr, reg_write,
           mem_to_reg, mem_write, branch, jump, reg_dst, alu_op, alu_funct,
           halt_out
  );
endinterface

// File: rtl/id_regfile.sv
// Two-read/one-write register file, $0 hardwired to zero.
// Optional write-first forwarding when ID_WB_BYPASS_EN is defined.
module id_regfile #(
  parameter  int unsigned DW      = 32,
  parameter  int unsigned REG_CNT = 32,
  localparam int unsigned AW      = $clog2(REG_CNT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] regs_q [REG_CNT];

  // Storage: clear on reset, writes to $0 dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(REG_CNT); i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Zero-latency read ports.
  always_comb begin
    rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
    rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];
`ifdef ID_WB_BYPASS_EN
    if (we_i && (waddr_i == raddr_a_i) && (raddr_a_i != '0)) rdata_a_o = wdata_i;
    if (we_i && (waddr_i == raddr_b_i) && (raddr_b_i != '0)) rdata_b_o = wdata_i;
`endif
  end

endmodule

// File: rtl/id_hazard_stage.sv
// ID stage: IF/ID register, decode, register file, load-use stall and
// halt drain. Build option: ID_WB_BYPASS_EN (write-back forwarding).
module id_hazard_stage
  import id_pkg::*;
#(
  parameter  int unsigned DW      = 32,
  parameter  int unsigned REG_CNT = 32,
  parameter  int unsigned DRAIN   = 4,
  localparam int unsigned AW      = $clog2(REG_CNT),
  localparam int unsigned CW      = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1
) (
  input logic               CLK,
  input logic               RST,
  id_hazard_stage_if.slave  bus
);

  halt_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;

  logic [AW-1:0] rs_addr_c, rt_addr_c;
  logic          load_use_c, stall_c;
  ctrl_t         ctrl_c;

  assign rs_addr_c  = AW'(instr_q[25:21]);
  assign rt_addr_c  = AW'(instr_q[20:16]);
  assign load_use_c = bus.ex_memtoreg && (bus.ex_rt_addr != '0) &&
                      ((bus.ex_rt_addr == rs_addr_c) || (bus.ex_rt_addr == rt_addr_c));
  // A held halt keeps the front end frozen from decode until reset.
  assign stall_c    = (state_q != ST_RUN) || (valid_q && load_use_c);
  assign ctrl_c     = (valid_q && !stall_c) ? decode(instr_q[31:26], instr_q[5:0]) : '0;

  // State and IF/ID register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // Next state: halt hold > flush > stall > load; halt arms the drain counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (state_q)
      ST_RUN: begin
        if (bus.flush_in) begin
          instr_d = '0;
          valid_d = 1'b0;
        end else if (!stall_c) begin
          instr_d = bus.instr_in;
          pc_d    = bus.pc_plus4_in;
          valid_d = 1'b1;
          if (bus.instr_in == HALT_INSTR) begin
            cnt_d   = CW'(DRAIN);
            state_d = (DRAIN == 0) ? ST_HALTED : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_HALTED;
      end
      ST_HALTED: ;
      default:   state_d = ST_RUN;
    endcase
  end

  id_regfile #(
    .DW      (DW),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk_i     (CLK),
    .rst_i     (RST),
    .we_i      (bus.wb_we),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data),
    .raddr_a_i (rs_addr_c),
    .raddr_b_i (rt_addr_c),
    .rdata_a_o (bus.rs_data),
    .rdata_b_o (bus.rt_data)
  );

  assign bus.stall_out    = stall_c;
  assign bus.valid_out    = valid_q;
  assign bus.pc_plus4_out = pc_q;
  assign bus.rs_addr      = rs_addr_c;
  assign bus.rt_addr      = rt_addr_c;
  assign bus.rd_addr      = AW'(instr_q[15:11]);
  assign bus.shamt        = instr_q[10:6];
  assign bus.imm_sext     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign bus.imm_zext     = {16'h0000, instr_q[15:0]};
  assign bus.jaddr        = instr_q[25:0];
  assign bus.reg_write    = ctrl_c.reg_write;
  assign bus.mem_to_reg   = ctrl_c.mem_to_reg;
  assign bus.mem_write    = ctrl_c.mem_write;
  assign bus.branch       = ctrl_c.branch;
  assign bus.jump         = ctrl_c.jump;
  assign bus.reg_dst      = ctrl_c.reg_dst;
  assign bus.alu_op       = ctrl_c.alu_op;
  assign bus.alu_funct    = ctrl_c.alu_funct;
  assign bus.halt_out     = (state_q == ST_HALTED);

endmodule
